// File: rtl/nx_node_pkg.sv
// Shared types and constants for the mesh-node sequential executor.
package nx_node_pkg;

  localparam int unsigned NUM_INS   = 8;
  localparam int unsigned NUM_OUTS  = 8;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned MAX_INSTR = 64;

  localparam int unsigned ADDR_W = $clog2(MAX_INSTR);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned SEL_W  = 3;

  // Instruction word layout, MSB to LSB.
  localparam int unsigned TRUTH_W     = 8;
  localparam int unsigned TRUTH_LSB   = 19;
  localparam int unsigned SRC_A_LSB   = 16;
  localparam int unsigned A_IP_BIT    = 15;
  localparam int unsigned SRC_B_LSB   = 12;
  localparam int unsigned B_IP_BIT    = 11;
  localparam int unsigned SRC_C_LSB   = 8;
  localparam int unsigned C_IP_BIT    = 7;
  localparam int unsigned TGT_LSB     = 4;
  localparam int unsigned OUT_EN_BIT  = 3;
  localparam int unsigned OUT_IDX_LSB = 0;
  localparam int unsigned INSTR_W     = TRUTH_LSB + TRUTH_W;

  typedef struct packed {
    logic [TRUTH_W-1:0] truth;
    logic [SEL_W-1:0]   src_a;
    logic               a_ip;
    logic [SEL_W-1:0]   src_b;
    logic               b_ip;
    logic [SEL_W-1:0]   src_c;
    logic               c_ip;
    logic [SEL_W-1:0]   tgt;
    logic               out_en;
    logic [SEL_W-1:0]   out_idx;
  } nx_instr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMMIT
  } exec_state_e;

  // Sequence lengths beyond the memory depth run the whole memory once.
  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] cnt);
    if (cnt > CNT_W'(MAX_INSTR)) begin
      return CNT_W'(MAX_INSTR);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/nx_node_exec_if.sv
// Load/trigger/result bundle between a node executor and its mesh controller.
interface nx_node_exec_if;
  import nx_node_pkg::*;

  logic                 ld_valid;
  logic [ADDR_W-1:0]    ld_addr;
  logic [INSTR_W-1:0]   ld_data;
  logic [CNT_W-1:0]     ld_count;
  logic                 ld_err;
  logic                 trigger;
  logic [NUM_INS-1:0]   inputs;
  logic                 busy;
  logic                 done;
  logic [NUM_OUTS-1:0]  outputs;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_count, trigger, inputs,
    input  ld_err, busy, done, outputs
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_count, trigger, inputs,
    output ld_err, busy, done, outputs
  );

endinterface

// File: rtl/nx_node_instr_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module nx_node_instr_mem
  import nx_node_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [MAX_INSTR];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/nx_node_exec.sv
// Sequential executor for one mesh node: runs one 3-input truth-table instruction per
// cycle over a working register file and commits node outputs atomically at the end.
module nx_node_exec
  import nx_node_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  nx_node_exec_if.slave  bus
);

  exec_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [NUM_REGS-1:0]  regs_q, regs_d;
  logic [NUM_INS-1:0]   snap_q, snap_d;
  logic [NUM_OUTS-1:0]  nxt_q, nxt_d;
  logic [NUM_OUTS-1:0]  outputs_q, outputs_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ld_err_q, ld_err_d;

  logic                 mem_we;
  logic [INSTR_W-1:0]   mem_rdata;
  nx_instr_t            instr;
  logic                 op_a, op_b, op_c;
  logic                 result;
  logic [CNT_W-1:0]     eff_count;
  logic                 last_instr;

  // Loads are only accepted while idle so a running sequence never sees its code change.
  assign mem_we = bus.ld_valid && (state_q == IDLE);

  nx_node_instr_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.ld_addr),
    .wdata (bus.ld_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  assign instr = nx_instr_t'(mem_rdata);

  // Operand fetch and truth-table lookup for the instruction at pc.
  always_comb begin
    op_a   = instr.a_ip ? snap_q[instr.src_a] : regs_q[instr.src_a];
    op_b   = instr.b_ip ? snap_q[instr.src_b] : regs_q[instr.src_b];
    op_c   = instr.c_ip ? snap_q[instr.src_c] : regs_q[instr.src_c];
    result = instr.truth[{op_a, op_b, op_c}];
  end

  // A load in the same cycle as a trigger takes effect first, so the start decision uses it.
  assign eff_count  = mem_we ? sat_count(bus.ld_count) : count_q;
  assign last_instr = ({1'b0, pc_q} == (count_q - CNT_W'(1)));

  // Next-state logic for the FSM, load handling and datapath registers.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    regs_d    = regs_q;
    snap_d    = snap_q;
    nxt_d     = nxt_q;
    outputs_d = outputs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ld_err_d  = bus.ld_valid && (state_q != IDLE);

    if (mem_we) begin
      count_d = sat_count(bus.ld_count);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          snap_d  = bus.inputs;
          nxt_d   = '0;
          pc_d    = '0;
          busy_d  = 1'b1;
          state_d = (eff_count == '0) ? COMMIT : RUN;
        end
      end
      RUN: begin
        regs_d[instr.tgt] = result;
        if (instr.out_en) begin
          nxt_d[instr.out_idx] = result;
        end
        pc_d = pc_q + ADDR_W'(1);
        if (last_instr) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        outputs_d = nxt_q;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any step in flight without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      count_q   <= '0;
      regs_q    <= '0;
      snap_q    <= '0;
      nxt_q     <= '0;
      outputs_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ld_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      regs_q    <= regs_d;
      snap_q    <= snap_d;
      nxt_q     <= nxt_d;
      outputs_q <= outputs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ld_err  = ld_err_q;
  assign bus.outputs = outputs_q;

endmodule

// File: tb/tb_nx_node_exec.sv
// Self-checking bench for nx_node_exec: directed vector table, corner-case sequences and
// randomized programs checked against a sequence-level reference model.
module tb_nx_node_exec;
  import nx_node_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nx_node_exec_if bus ();

  nx_node_exec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [INSTR_W-1:0] mem_m [MAX_INSTR];
  int                 count_m;
  logic [7:0]         regs_m;
  logic [7:0]         outs_m;

  typedef struct {
    int         prog;
    logic [7:0] in;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(
    input logic [7:0] truth,
    input logic [2:0] sa, input logic aip,
    input logic [2:0] sb, input logic bip,
    input logic [2:0] sc, input logic cip,
    input logic [2:0] tgt, input logic oen, input logic [2:0] oidx);
    return {truth, sa, aip, sb, bip, sc, cip, tgt, oen, oidx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-sequence evaluation straight from the instruction semantics.
  task automatic model_step(input logic [7:0] in);
    logic [7:0] nxt;
    logic [INSTR_W-1:0] w;
    logic [7:0] tt;
    logic a, b, c, r;
    nxt = '0;
    for (int i = 0; i < count_m; i++) begin
      w  = mem_m[i];
      tt = w[26:19];
      a  = w[15] ? in[w[18:16]] : regs_m[w[18:16]];
      b  = w[11] ? in[w[14:12]] : regs_m[w[14:12]];
      c  = w[7]  ? in[w[10:8]]  : regs_m[w[10:8]];
      r  = tt[{a, b, c}];
      regs_m[w[6:4]] = r;
      if (w[3]) nxt[w[2:0]] = r;
    end
    outs_m = nxt;
  endtask

  task automatic model_load(input int addr, input logic [INSTR_W-1:0] word, input int cnt);
    mem_m[addr] = word;
    count_m = (cnt > int'(MAX_INSTR)) ? int'(MAX_INSTR) : cnt;
  endtask

  task automatic load(input int addr, input logic [INSTR_W-1:0] word, input int cnt);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = ADDR_W'(addr);
    bus.ld_data  = word;
    bus.ld_count = CNT_W'(cnt);
    tick();
    bus.ld_valid = 1'b0;
    model_load(addr, word, cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    regs_m  = '0;
    outs_m  = '0;
    count_m = 0;
  endtask

  // Triggers one step (optionally with a same-cycle load) and waits for done, bounded.
  task automatic run_step(input logic [7:0] in, input bit with_ld, input int ld_a,
                          input logic [INSTR_W-1:0] ld_w, input int ld_c,
                          output int lat, output logic [7:0] outv);
    int n;
    bit got;
    bus.trigger = 1'b1;
    bus.inputs  = in;
    if (with_ld) begin
      bus.ld_valid = 1'b1;
      bus.ld_addr  = ADDR_W'(ld_a);
      bus.ld_data  = ld_w;
      bus.ld_count = CNT_W'(ld_c);
    end
    tick();
    bus.trigger  = 1'b0;
    bus.ld_valid = 1'b0;
    bus.inputs   = 8'($urandom);
    if (with_ld) model_load(ld_a, ld_w, ld_c);
    model_step(in);
    chk("busy_after_trigger", bus.busy, 1);
    n = 0;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      n++;
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    lat  = got ? n : -1;
    outv = bus.outputs;
    chk("busy_at_done", bus.busy, 0);
  endtask

  logic [INSTR_W-1:0] p1, p2_0, p2_1, p2_2, loopw, badw;
  int lat, cur_prog, nerr, ndone;
  logic [7:0] outv, inr;

  initial begin
    p1    = mk(8'hF0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0);
    p2_0  = mk(8'hC0, 3'd0, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
    p2_1  = mk(8'h0F, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b0, 3'd0);
    p2_2  = mk(8'hF0, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 3'd3);
    loopw = mk(8'h0F, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0);
    badw  = mk(8'hFF, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5);

    vecs[0] = '{1, 8'h04, 8'h01, 2};
    vecs[1] = '{1, 8'h00, 8'h00, 2};
    vecs[2] = '{1, 8'hFB, 8'h00, 2};
    vecs[3] = '{1, 8'hFF, 8'h01, 2};
    vecs[4] = '{2, 8'h03, 8'h00, 4};
    vecs[5] = '{2, 8'h01, 8'h08, 4};
    vecs[6] = '{2, 8'h00, 8'h08, 4};
    vecs[7] = '{2, 8'hFF, 8'h00, 4};
    vecs[8] = '{2, 8'h02, 8'h08, 4};

    bus.ld_valid = 1'b0;
    bus.ld_addr  = '0;
    bus.ld_data  = '0;
    bus.ld_count = '0;
    bus.trigger  = 1'b0;
    bus.inputs   = '0;
    for (int i = 0; i < int'(MAX_INSTR); i++) mem_m[i] = '0;

    // Reset state.
    do_reset();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ld_err", bus.ld_err, 0);
    chk("rst_outputs", bus.outputs, 0);

    // Directed vector table.
    cur_prog = 0;
    foreach (vecs[i]) begin
      if (vecs[i].prog != cur_prog) begin
        if (vecs[i].prog == 1) begin
          load(0, p1, 1);
        end else begin
          load(0, p2_0, 3);
          load(1, p2_1, 3);
          load(2, p2_2, 3);
        end
        chk("ld_err_idle", bus.ld_err, 0);
        cur_prog = vecs[i].prog;
      end
      run_step(vecs[i].in, 0, 0, '0, 0, lat, outv);
      chk($sformatf("vec%0d_outputs", i), outv, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Loopback toggle, then reset in the middle of a run.
    do_reset();
    load(0, loopw, 1);
    run_step(8'h00, 0, 0, '0, 0, lat, outv);
    chk("loop1", outv, 8'h01);
    run_step(8'h00, 0, 0, '0, 0, lat, outv);
    chk("loop2", outv, 8'h00);
    run_step(8'h00, 0, 0, '0, 0, lat, outv);
    chk("loop3", outv, 8'h01);
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrun_rst_outputs", bus.outputs, 0);
    chk("midrun_rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    regs_m = '0;
    outs_m = '0;
    count_m = 0;
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.done) ndone++;
    end
    chk("midrun_rst_no_done", ndone, 0);
    load(0, loopw, 1);
    run_step(8'h00, 0, 0, '0, 0, lat, outv);
    chk("regs_cleared_by_rst", outv, 8'h01);

    // Trigger and load while busy are both rejected.
    for (int i = 0; i < 4; i++) load(i, loopw, 4);
    bus.trigger = 1'b1;
    bus.inputs  = 8'h00;
    tick();
    model_step(8'h00);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 3;
    bus.ld_data  = badw;
    bus.ld_count = 1;
    tick();
    bus.trigger  = 1'b0;
    bus.ld_valid = 1'b0;
    nerr = 0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.ld_err) nerr++;
      if (bus.done) ndone++;
      tick();
    end
    chk("busy_ld_err_pulses", nerr, 1);
    chk("busy_single_done", ndone, 1);
    chk("busy_outputs", bus.outputs, outs_m);
    run_step(8'h00, 0, 0, '0, 0, lat, outv);
    chk("rerun_outputs", outv, outs_m);
    chk("rerun_latency", lat, 5);

    // Empty sequence.
    load(5, mk(8'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 7), 0);
    run_step(8'hFF, 0, 0, '0, 0, lat, outv);
    chk("count0_latency", lat, 1);
    chk("count0_outputs", outv, 0);
    tick();
    chk("done_one_cycle", bus.done, 0);

    // Randomized programs against the model.
    for (int a = 0; a < int'(MAX_INSTR); a++) load(a, INSTR_W'($urandom), 64);
    for (int t = 0; t < 16; t++) begin
      load($urandom_range(0, MAX_INSTR - 1), INSTR_W'($urandom), $urandom_range(0, MAX_INSTR));
      inr = 8'($urandom);
      run_step(inr, 0, 0, '0, 0, lat, outv);
      chk($sformatf("rand%0d_outputs", t), outv, outs_m);
      chk($sformatf("rand%0d_latency", t), lat, count_m + 1);
    end

    // Oversized count saturates to the memory depth.
    load(7, INSTR_W'($urandom), MAX_INSTR + 5);
    run_step(8'($urandom), 0, 0, '0, 0, lat, outv);
    chk("sat_latency", lat, MAX_INSTR + 1);
    chk("sat_outputs", outv, outs_m);

    // Load and trigger together: the step sees the new word and count.
    run_step(8'h20, 1, 0, mk(8'hF0, 3'd5, 1'b1, 0, 0, 0, 0, 3'd3, 1'b1, 3'd6), 1, lat, outv);
    chk("ld_trig_outputs", outv, 8'h40);
    chk("ld_trig_latency", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
